// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory port between instruction fetch and load/store.
// Each granted access holds the address on the memory port for MEM_LATENCY cycles. Write
// enables are asserted only in the last of those cycles. Read data and the memory
// exception are captured on that edge and returned in a one-cycle done pulse (RESP).
// Data requests normally win. Fetch is forced once STARVE_LIMIT data grants have been
// made while fetch was waiting.
//
// Ports:
//   clk, rst_b                            clock, async active-low reset
//   if_req/if_addr                        fetch request
//   if_rdata/if_done/if_excpt             fetch response
//   d_req/d_addr/d_wdata/d_we             data request (d_we==0 is a load)
//   d_rdata/d_done/d_excpt                data response
//   mem_addr/mem_data_in/mem_write_en     memory port outputs
//   mem_data_out/mem_excpt                memory port inputs
//   perf_if_grants/perf_d_grants/perf_conflicts
//                                         32-bit event counters, present only when
//                                         MIPS_MEM_ARB_PERF_EN is defined
module mips_mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_excpt,
    input  logic        d_req,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_excpt,
`ifdef MIPS_MEM_ARB_PERF_EN
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts,
`endif
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_write_en,
    input  logic [31:0] mem_data_out,
    input  logic        mem_excpt
);

    localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            owner_data;   // 1: data requester owns the current access
    logic [29:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      we_q;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     if_rdata_q;
    logic [31:0]     d_rdata_q;
    logic            excpt_q;
    logic            grant_fetch;
    logic            in_access;
    logic            last_access;

    // Fetch wins when data is idle, or when data has starved fetch long enough.
    assign grant_fetch = if_req && (!d_req || (starve_cnt == SW'(STARVE_LIMIT)));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= StIdle;
            cnt        <= '0;
            owner_data <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            excpt_q    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (if_req || d_req) begin
                        state <= StAccess;
                        cnt   <= CW'(MEM_LATENCY - 1);
                        if (grant_fetch) begin
                            owner_data <= 1'b0;
                            addr_q     <= if_addr;
                            wdata_q    <= '0;
                            we_q       <= '0;
                            starve_cnt <= '0;
                        end else begin
                            owner_data <= 1'b1;
                            addr_q     <= d_addr;
                            wdata_q    <= d_wdata;
                            we_q       <= d_we;
                            if (if_req && (starve_cnt != SW'(STARVE_LIMIT))) begin
                                starve_cnt <= starve_cnt + SW'(1);
                            end
                        end
                    end
                end
                StAccess: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        excpt_q <= mem_excpt;
                        if (owner_data) d_rdata_q <= mem_data_out;
                        else            if_rdata_q <= mem_data_out;
                        state <= StResp;
                    end
                end
                StResp:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign in_access   = (state == StAccess);
    assign last_access = in_access && (cnt == '0);

    // Memory port is quiet outside ACCESS; reset forces the state to IDLE, so the
    // write enable drops together with rst_b.
    assign mem_addr     = in_access ? addr_q : '0;
    assign mem_data_in  = in_access ? wdata_q : '0;
    assign mem_write_en = last_access ? we_q : '0;

    assign if_done  = (state == StResp) && !owner_data;
    assign d_done   = (state == StResp) && owner_data;
    assign if_excpt = if_done && excpt_q;
    assign d_excpt  = d_done && excpt_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef MIPS_MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            perf_if_grants <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else if (state == StIdle) begin
            if (grant_fetch)                perf_if_grants <= perf_if_grants + 32'd1;
            else if (d_req)                 perf_d_grants  <= perf_d_grants + 32'd1;
            if (if_req && d_req)            perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter. The driver grants transactions with a
// transaction-level model (arbiter free time, starvation count). Expected done pulses
// and writes are pushed to queues, and a negedge monitor pops and compares them.
module tb_mips_mem_arbiter;
    localparam int LAT = 2;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0;
    logic [29:0] if_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_we = '0;
    logic [31:0] if_rdata, d_rdata, mem_data_in, mem_data_out;
    logic        if_done, if_excpt, d_done, d_excpt, mem_excpt;
    logic [29:0] mem_addr;
    logic [3:0]  mem_write_en;
`ifdef MIPS_MEM_ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

    mips_mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_b(rst_b),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .if_excpt(if_excpt),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_rdata(d_rdata), .d_done(d_done), .d_excpt(d_excpt),
`ifdef MIPS_MEM_ARB_PERF_EN
        .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts),
`endif
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out), .mem_excpt(mem_excpt)
    );

    always #5 clk = ~clk;

    // Combinational memory: content and fault are functions of the address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h00100000) return 32'h24020005;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction
    function automatic logic mem_bad(input logic [29:0] a);
        return a[29:27] == 3'b111;
    endfunction
    assign mem_data_out = mem_word(mem_addr);
    assign mem_excpt    = mem_bad(mem_addr);

    typedef struct { logic fetch; logic [31:0] rdata; logic excpt; int cyc; } done_t;
    typedef struct { logic [29:0] addr; logic [31:0] data; logic [3:0] we; int cyc; } wr_t;
    done_t dq[$];
    wr_t   wq[$];

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state.
    logic        if_pend = 0, d_pend = 0, mutate = 0;
    int          if_done_at = -1, d_done_at = -1, idle_at = 0, starve = 0;
    int          acc_lo = 1, acc_hi = 0;
    logic [29:0] acc_a = '0;
    logic [31:0] acc_wd = '0;
    logic        acc_isd = 0;
    logic [31:0] last_if = '0, last_d = '0;
    int          n_if = 0, n_d = 0, n_conf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_fetch(input logic [29:0] a);
        if_pend = 1; if_req = 1; if_addr = a; if_done_at = -1;
    endtask
    task automatic new_data(input logic [29:0] a, input logic [31:0] w, input logic [3:0] we);
        d_pend = 1; d_req = 1; d_addr = a; d_wdata = w; d_we = we; d_done_at = -1;
    endtask

    // One cycle of requester behaviour plus the arbitration decision, called just after
    // a falling edge; the next rising edge samples whatever is driven here.
    task automatic drive_cycle(input int p_if, input int p_d);
        int  c;
        logic want_if, want_d, fetch_wins;
        c = cyc;
        if (if_done_at == c) begin if_pend = 0; if_done_at = -1; if_req = 0; end
        if (d_done_at == c)  begin d_pend = 0;  d_done_at = -1;  d_req = 0;  end
        // Granted requesters may wander; the arbiter must ignore it.
        if (mutate && if_done_at > c && $urandom_range(3) == 0) begin
            if_req = 1'($urandom_range(1)); if_addr = 30'($urandom);
        end
        if (mutate && d_done_at > c && $urandom_range(3) == 0) begin
            d_req = 1'($urandom_range(1)); d_addr = 30'($urandom);
            d_wdata = $urandom; d_we = 4'($urandom);
        end
        if (!if_pend && int'($urandom_range(99)) < p_if) new_fetch(30'($urandom));
        if (!d_pend && int'($urandom_range(99)) < p_d)
            new_data(30'($urandom), $urandom, $urandom_range(1) ? 4'h0 : 4'($urandom));
        if (idle_at <= c) begin
            if (if_req && d_req) n_conf++;
            want_if = if_pend && if_done_at < 0;
            want_d  = d_pend && d_done_at < 0;
            if (want_if || want_d) begin
                fetch_wins = want_if && (!want_d || starve == LIM);
                acc_lo = c + 1; acc_hi = c + LAT;
                if (fetch_wins) begin
                    starve = 0; n_if++;
                    if_done_at = c + LAT + 1;
                    acc_a = if_addr; acc_isd = 0;
                    dq.push_back('{1'b1, mem_word(if_addr), mem_bad(if_addr), c + LAT + 1});
                end else begin
                    if (want_if && starve < LIM) starve++;
                    n_d++;
                    d_done_at = c + LAT + 1;
                    acc_a = d_addr; acc_wd = d_wdata; acc_isd = 1;
                    dq.push_back('{1'b0, mem_word(d_addr), mem_bad(d_addr), c + LAT + 1});
                    if (d_we != 0) wq.push_back('{d_addr, d_wdata, d_we, c + LAT});
                end
                idle_at = c + LAT + 2;
            end
        end
    endtask

    task automatic step(input int p_if, input int p_d);
        @(negedge clk); #1;
        drive_cycle(p_if, p_d);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (!if_pend && !d_pend && idle_at <= cyc && dq.size() == 0 && wq.size() == 0)
                return;
            step(0, 0);
        end
        check("drain_timeout", 1, 0);
    endtask

    // Monitor.
    always @(negedge clk) begin
        done_t e;
        wr_t   w;
        if (rst_b) begin
            check("done_exclusive", 32'(if_done & d_done), 0);
            if (if_done || d_done) begin
                if (dq.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    e = dq.pop_front();
                    check("done_owner", 32'(if_done), 32'(e.fetch));
                    check("done_cycle", cyc, e.cyc);
                    if (e.fetch) begin
                        check("if_rdata", if_rdata, e.rdata);
                        check("if_excpt", 32'(if_excpt), 32'(e.excpt));
                        last_if = e.rdata;
                    end else begin
                        check("d_rdata", d_rdata, e.rdata);
                        check("d_excpt", 32'(d_excpt), 32'(e.excpt));
                        last_d = e.rdata;
                    end
                end
            end
            if (!if_done) begin
                check("if_excpt_quiet", 32'(if_excpt), 0);
                check("if_rdata_hold", if_rdata, last_if);
            end
            if (!d_done) begin
                check("d_excpt_quiet", 32'(d_excpt), 0);
                check("d_rdata_hold", d_rdata, last_d);
            end
            if (cyc >= acc_lo && cyc <= acc_hi) begin
                check("access_addr", 32'(mem_addr), 32'(acc_a));
                if (acc_isd) check("access_wdata", mem_data_in, acc_wd);
                if (cyc != acc_hi) check("early_we", 32'(mem_write_en), 0);
            end else if (cyc >= idle_at) begin
                check("idle_addr", 32'(mem_addr), 0);
                check("idle_we", 32'(mem_write_en), 0);
            end
            if (mem_write_en != 0) begin
                if (wq.size() == 0) check("unexpected_write", 32'(mem_write_en), 0);
                else begin
                    w = wq.pop_front();
                    check("write_cycle", cyc, w.cyc);
                    check("write_addr", 32'(mem_addr), 32'(w.addr));
                    check("write_data", mem_data_in, w.data);
                    check("write_we", 32'(mem_write_en), 32'(w.we));
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_if_done", 32'(if_done), 0);
        check("rst_d_done", 32'(d_done), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_if_excpt", 32'(if_excpt), 0);
        check("rst_d_excpt", 32'(d_excpt), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_data_in", mem_data_in, 0);
        check("rst_mem_we", 32'(mem_write_en), 0);
        #1 rst_b = 1; idle_at = cyc;

        // Single fetch, store, conflict.
        step(0, 0);
        new_fetch(30'h00100000); drive_cycle(0, 0);
        drain();
        @(negedge clk); #1;
        new_data(30'h04000000, 32'hDEADBEEF, 4'hF); drive_cycle(0, 0);
        drain();
        @(negedge clk); #1;
        new_fetch(30'h00100004); new_data(30'h00000040, 32'h0, 4'h0); drive_cycle(0, 0);
        drain();

        // Starvation: both requesters continuously busy.
        repeat (80) step(100, 100);
        drain();

        // Random traffic, with granted requesters wandering.
        mutate = 1;
        repeat (1500) step(50, 50);
        repeat (800) step(25, 90);
        mutate = 0;
        drain();

        // Reset during the write cycle of a store.
        @(negedge clk); #1;
        new_data(30'h00012345, 32'hCAFEF00D, 4'h3); drive_cycle(0, 0);
        step(0, 0);
        @(negedge clk); #1;
        rst_b = 0;
        #1;
        check("midrst_we", 32'(mem_write_en), 0);
        check("midrst_d_done", 32'(d_done), 0);
        check("midrst_mem_addr", 32'(mem_addr), 0);
        void'(dq.pop_back());
        acc_lo = 1; acc_hi = 0;
        d_pend = 0; d_done_at = -1; d_req = 0; if_pend = 0; if_done_at = -1; if_req = 0;
        starve = 0; last_if = '0; last_d = '0; n_if = 0; n_d = 0; n_conf = 0;
        repeat (2) @(negedge clk);
        #1 rst_b = 1; idle_at = cyc;
        new_fetch(30'h00100000); drive_cycle(0, 0);
        drain();

        check("queue_done_empty", dq.size(), 0);
        check("queue_write_empty", wq.size(), 0);
`ifdef MIPS_MEM_ARB_PERF_EN
        check("perf_if_grants", perf_if_grants, n_if);
        check("perf_d_grants", perf_d_grants, n_d);
        check("perf_conflicts", perf_conflicts, n_conf);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
